button_event_decoder: RTL and testbench
=======================================

Name: button_event_decoder

Overview:
- Consumer end of the debounced button path: takes the clean, clock-synchronous level from the debouncer and turns it into single-cycle event strobes.
- Strobes: press, release, long-press, and (optional) auto-repeat, plus a "held" level.
- Feeds the display/mode control logic so it never edge-detects or times button levels itself.

Parameters:
- PRESCALE_WIDTH, 16: prescaler width; one tick every 2^PRESCALE_WIDTH clocks while pressed.
- TICK_WIDTH, 8: width of the tick counter.
- LONG_TICKS, 30: ticks of continuous press before long_press; legal range 1..2^TICK_WIDTH.
- REPEAT_TICKS, 5: ticks between repeat strobes once held; legal range 1..2^TICK_WIDTH.

Ports:
- clock, input, 1: sole clock; all logic is on its rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- in, input, 1: debounced button level, 1 = pressed; already synchronous to clock, no synchroniser inside.
- press, output, 1: one-cycle strobe on press.
- release, output, 1: one-cycle strobe on release.
- long_press, output, 1: one-cycle strobe when the press reaches LONG_TICKS.
- repeat, output, 1: one-cycle strobe every REPEAT_TICKS while held.
- held, output, 1: level, high in HELD state.

Behaviour:
- Interface decision: one clock (clock); reset is synchronous and active-low (reset_n).
- Reset (reset_n=0 at a rising edge):
  - state=IDLE, in_prev=0, prescaler=0, tick_count=0.
  - All outputs 0 after that edge.
  - Overrides everything, including mid-press; no release strobe is generated by reset.
- All outputs are registered. Strobes are high for exactly one cycle.
- in_prev is registered from in on every edge.
- tick is combinational: prescaler == all-ones.
- IDLE:
  - At an edge with in=1 and in_prev=0: press=1, go to PRESSED, prescaler=0, tick_count=0.
  - If in is high when reset deasserts, that counts as a new press, because in_prev resets to 0.
- PRESSED:
  - prescaler increments every edge and wraps.
  - On a tick edge with tick_count == LONG_TICKS-1: long_press=1, go to HELD, held=1, tick_count=0.
  - On any other tick edge: tick_count increments.
- HELD:
  - held=1; prescaler keeps running.
  - On a tick edge with tick_count == REPEAT_TICKS-1: repeat=1, tick_count=0.
  - On any other tick edge: tick_count increments.
- Release from PRESSED or HELD:
  - At an edge with in=0: release=1, go to IDLE, held=0, counters cleared.
  - Release takes priority over a coincident long_press or repeat; neither fires on that edge.
- Timing, with press asserted in cycle P:
  - long_press is asserted in cycle P + LONG_TICKS*2^PRESCALE_WIDTH.
  - Repeat strobes follow at every REPEAT_TICKS*2^PRESCALE_WIDTH cycles after that.
- Strobe exclusivity:
  - press and release are never high together.
  - A release on the edge after press is legal; it gives a 1-cycle gap between the strobes.
- Arithmetic: counters are unsigned and wrap naturally. tick_count never exceeds max(LONG_TICKS, REPEAT_TICKS)-1 inside legal parameter ranges.
- States: IDLE, PRESSED, HELD; 2-bit encoding. Unused codes return to IDLE on the next edge with all outputs 0.

Optional Feature:
- Macro: BUTTON_EVENT_REPEAT_EN.
- Defined: HELD generates repeat strobes as described above.
- Undefined:
  - repeat is tied 0.
  - HELD only holds held=1 until release.
  - The prescaler and tick counter stop in HELD (power saving).
  - long_press and release timing are unchanged.

Test Plan:
- Parameters for all scenarios: PRESCALE_WIDTH=2, LONG_TICKS=3, REPEAT_TICKS=2.
- Reset: reset_n=0 for 3 cycles with in toggling -> all outputs 0 throughout; with in=1 at deassertion, press=1 on the first edge after release of reset.
- Short press: in 0->1 for 5 cycles then 0 -> press pulses once 1 cycle after the rise; release pulses once 1 cycle after the fall; long_press, repeat and held stay 0.
- Long press with repeat (macro defined): in held high 40 cycles ->
  - long_press at P+12, held=1 from P+12.
  - repeat at P+20, P+28, P+36.
  - release on the cycle after in falls; held=0 then.
- Release coincident with the long tick: in falls so the edge where long_press would fire (P+12) sees in=0 -> release=1, long_press=0, state IDLE.
- Macro undefined: same 40-cycle hold -> long_press at P+12, held=1, repeat never asserted, release as normal.
- Reset mid-HELD: assert reset_n=0 at P+15 -> held=0 and release=0 on that edge; with in=1 at deassertion, a fresh press strobe follows.

Source files
------------

// File: rtl/button_event_decoder.sv
// Button event decoder: turns a debounced, synchronous button level into press/release/long-press strobes.
// Define BUTTON_EVENT_REPEAT_EN to enable auto-repeat strobes while held; otherwise the timers freeze in HELD.
module button_event_decoder #(
   parameter int PRESCALE_WIDTH = 16,
   parameter int TICK_WIDTH     = 8,
   parameter int LONG_TICKS     = 30,
   parameter int REPEAT_TICKS   = 5
) (
   input  logic clock,
   input  logic reset_n,
   input  logic in,
   output logic press,
   output logic release_strobe,
   output logic long_press,
   output logic repeat_strobe,
   output logic held
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } state_t;

   localparam logic [TICK_WIDTH-1:0] LONG_LAST = TICK_WIDTH'(LONG_TICKS - 1);

   generate
      if (LONG_TICKS < 1 || LONG_TICKS > (1 << TICK_WIDTH)) begin : g_bad_long
         $error("LONG_TICKS out of range for TICK_WIDTH");
      end
      if (REPEAT_TICKS < 1 || REPEAT_TICKS > (1 << TICK_WIDTH)) begin : g_bad_repeat
         $error("REPEAT_TICKS out of range for TICK_WIDTH");
      end
   endgenerate

   state_t                    state_reg;
   logic                      in_prev_reg;
   logic [PRESCALE_WIDTH-1:0] prescaler_reg;
   logic [TICK_WIDTH-1:0]     tick_count_reg;
   logic                      tick;

   assign tick = &prescaler_reg;

`ifdef BUTTON_EVENT_REPEAT_EN
   localparam logic [TICK_WIDTH-1:0] REPEAT_LAST = TICK_WIDTH'(REPEAT_TICKS - 1);
`else
   assign repeat_strobe = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         in_prev_reg    <= 1'b0;
         prescaler_reg  <= '0;
         tick_count_reg <= '0;
         press          <= 1'b0;
         release_strobe <= 1'b0;
         long_press     <= 1'b0;
         held           <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
         repeat_strobe  <= 1'b0;
`endif
      end else begin
         in_prev_reg    <= in;
         press          <= 1'b0;
         release_strobe <= 1'b0;
         long_press     <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
         repeat_strobe  <= 1'b0;
`endif
         case (state_reg)
            IDLE: begin
               held <= 1'b0;
               if (in && !in_prev_reg) begin
                  press          <= 1'b1;
                  state_reg      <= PRESSED;
                  prescaler_reg  <= '0;
                  tick_count_reg <= '0;
               end
            end

            PRESSED: begin
               // Release wins over a long-press tick landing on the same edge.
               if (!in) begin
                  release_strobe <= 1'b1;
                  state_reg      <= IDLE;
                  held           <= 1'b0;
                  prescaler_reg  <= '0;
                  tick_count_reg <= '0;
               end else begin
                  prescaler_reg <= prescaler_reg + 1'b1;
                  if (tick) begin
                     if (tick_count_reg == LONG_LAST) begin
                        long_press     <= 1'b1;
                        state_reg      <= HELD;
                        held           <= 1'b1;
                        tick_count_reg <= '0;
                     end else begin
                        tick_count_reg <= tick_count_reg + 1'b1;
                     end
                  end
               end
            end

            HELD: begin
               if (!in) begin
                  release_strobe <= 1'b1;
                  state_reg      <= IDLE;
                  held           <= 1'b0;
                  prescaler_reg  <= '0;
                  tick_count_reg <= '0;
               end else begin
                  held <= 1'b1;
`ifdef BUTTON_EVENT_REPEAT_EN
                  prescaler_reg <= prescaler_reg + 1'b1;
                  if (tick) begin
                     if (tick_count_reg == REPEAT_LAST) begin
                        repeat_strobe  <= 1'b1;
                        tick_count_reg <= '0;
                     end else begin
                        tick_count_reg <= tick_count_reg + 1'b1;
                     end
                  end
`endif
               end
            end

            default: begin
               state_reg      <= IDLE;
               held           <= 1'b0;
               prescaler_reg  <= '0;
               tick_count_reg <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with PRESCALE_WIDTH=2, LONG_TICKS=3, REPEAT_TICKS=2.
// Expected vectors are {press, release, long_press, repeat, held}; repeat expectations follow BUTTON_EVENT_REPEAT_EN.
module tb_button_event_decoder;

   logic clock = 1'b0;
   logic reset_n;
   logic in;
   logic press, release_strobe, long_press, repeat_strobe, held;

   int vectors    = 0;
   int miscompares = 0;

`ifdef BUTTON_EVENT_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   button_event_decoder #(
      .PRESCALE_WIDTH(2),
      .TICK_WIDTH    (8),
      .LONG_TICKS    (3),
      .REPEAT_TICKS  (2)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .in            (in),
      .press         (press),
      .release_strobe(release_strobe),
      .long_press    (long_press),
      .repeat_strobe (repeat_strobe),
      .held          (held)
   );

   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      reset_n = 1'b0;
      in      = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in = ~in;
         cyc();
         obs = {press, release_strobe, long_press, repeat_strobe, held};
         vectors++;
         if (obs !== 5'b00000) begin
            $display("FAIL reset_hold cycle %0d: got %b expected %b", k, obs, 5'b00000);
            miscompares++;
         end
      end
      in      = 1'b1;
      reset_n = 1'b1;
      cyc();
      obs = {press, release_strobe, long_press, repeat_strobe, held};
      vectors++;
      if (obs !== 5'b10000) begin
         $display("FAIL reset_exit_press: got %b expected %b", obs, 5'b10000);
         miscompares++;
      end
      in = 1'b0;
      cyc();
      obs = {press, release_strobe, long_press, repeat_strobe, held};
      vectors++;
      if (obs !== 5'b01000) begin
         $display("FAIL reset_exit_release: got %b expected %b", obs, 5'b01000);
         miscompares++;
      end
      cyc();
      $display("test_reset done");
   endtask

   task automatic test_short_press();
      logic [4:0] obs, exp;
      in = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         if (k == 5) in = 1'b0;
         cyc();
         exp = (k == 0) ? 5'b10000 : (k == 5) ? 5'b01000 : 5'b00000;
         obs = {press, release_strobe, long_press, repeat_strobe, held};
         vectors++;
         if (obs !== exp) begin
            $display("FAIL short_press k=%0d: got %b expected %b", k, obs, exp);
            miscompares++;
         end
      end
      $display("test_short_press done");
   endtask

   task automatic test_long_press();
      logic [4:0] obs, exp;
      bit rep;
      in = 1'b1;
      for (int k = 0; k <= 42; k++) begin
         if (k == 40) in = 1'b0;
         cyc();
         rep = REP_EN && (k == 20 || k == 28 || k == 36);
         exp = {k == 0, k == 40, k == 12, rep, k >= 12 && k < 40};
         obs = {press, release_strobe, long_press, repeat_strobe, held};
         vectors++;
         if (obs !== exp) begin
            $display("FAIL long_press k=%0d: got %b expected %b", k, obs, exp);
            miscompares++;
         end
      end
      $display("test_long_press done (repeat %0d)", REP_EN);
   endtask

   task automatic test_release_on_long_tick();
      logic [4:0] obs, exp;
      in = 1'b1;
      for (int k = 0; k <= 20; k++) begin
         if (k == 12) in = 1'b0;
         cyc();
         exp = {k == 0, k == 12, 1'b0, 1'b0, 1'b0};
         obs = {press, release_strobe, long_press, repeat_strobe, held};
         vectors++;
         if (obs !== exp) begin
            $display("FAIL release_on_long_tick k=%0d: got %b expected %b", k, obs, exp);
            miscompares++;
         end
      end
      $display("test_release_on_long_tick done");
   endtask

   task automatic test_reset_mid_held();
      logic [4:0] obs, exp;
      in = 1'b1;
      for (int k = 0; k <= 14; k++) begin
         cyc();
         exp = {k == 0, 1'b0, k == 12, 1'b0, k >= 12};
         obs = {press, release_strobe, long_press, repeat_strobe, held};
         vectors++;
         if (obs !== exp) begin
            $display("FAIL mid_held_run k=%0d: got %b expected %b", k, obs, exp);
            miscompares++;
         end
      end
      reset_n = 1'b0;
      cyc();
      obs = {press, release_strobe, long_press, repeat_strobe, held};
      vectors++;
      if (obs !== 5'b00000) begin
         $display("FAIL mid_held_reset: got %b expected %b", obs, 5'b00000);
         miscompares++;
      end
      reset_n = 1'b1;
      cyc();
      obs = {press, release_strobe, long_press, repeat_strobe, held};
      vectors++;
      if (obs !== 5'b10000) begin
         $display("FAIL mid_held_fresh_press: got %b expected %b", obs, 5'b10000);
         miscompares++;
      end
      in = 1'b0;
      cyc();
      obs = {press, release_strobe, long_press, repeat_strobe, held};
      vectors++;
      if (obs !== 5'b01000) begin
         $display("FAIL mid_held_release: got %b expected %b", obs, 5'b01000);
         miscompares++;
      end
      cyc();
      $display("test_reset_mid_held done");
   endtask

   task automatic test_back_to_back();
      logic [4:0] obs, exp;
      for (int k = 0; k < 6; k++) begin
         in = (k % 2 == 0);
         cyc();
         exp = (k % 2 == 0) ? 5'b10000 : 5'b01000;
         obs = {press, release_strobe, long_press, repeat_strobe, held};
         vectors++;
         if (obs !== exp) begin
            $display("FAIL back_to_back k=%0d: got %b expected %b", k, obs, exp);
            miscompares++;
         end
      end
      cyc();
      obs = {press, release_strobe, long_press, repeat_strobe, held};
      vectors++;
      if (obs !== 5'b00000) begin
         $display("FAIL back_to_back_idle: got %b expected %b", obs, 5'b00000);
         miscompares++;
      end
      $display("test_back_to_back done");
   endtask

   initial begin
      test_reset();
      test_short_press();
      test_long_press();
      test_release_on_long_tick();
      test_reset_mid_held();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
